// File: rtl/mdu_pkg.sv
// Shared opcode encodings and operation-class helpers for the multiply/divide unit.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU accumulate operations).
package mdu_pkg;

    localparam int MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8,
        MADD    = 4'd9,
        MADDU   = 4'd10
    } md_op_e;

    function automatic logic is_start_class(input md_op_e op);
        logic res;
        case (op)
            MULT, MULTU, DIV, DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU:            res = 1'b1;
`endif
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_div_class(input md_op_e op);
        logic res;
        case (op)
            DIV, DIVU: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product, quotient and remainder from the latched operands.
// Optional feature macro: MDU_MADD_EN (accumulate onto the supplied HI/LO base).
module mdu_arith
    import mdu_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] udivisor_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] sdivisor_s;
    logic [31:0] mq_s;
    logic [31:0] mr_s;
    logic [31:0] sq_s;
    logic [31:0] sr_s;

    assign prod_s_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign prod_u_s = {32'd0, a_i} * {32'd0, b_i};

    // A zero divisor is replaced by one so the dividers never see it; the commit is suppressed instead.
    assign udivisor_s = (b_i == 32'd0) ? 32'd1 : b_i;
    assign uq_s       = a_i / udivisor_s;
    assign ur_s       = a_i % udivisor_s;

    // Signed divide on magnitudes: 0x80000000 / -1 wraps naturally to 0x80000000 with zero remainder.
    assign abs_a_s    = a_i[31] ? (32'd0 - a_i) : a_i;
    assign abs_b_s    = b_i[31] ? (32'd0 - b_i) : b_i;
    assign sdivisor_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
    assign mq_s       = abs_a_s / sdivisor_s;
    assign mr_s       = abs_a_s % sdivisor_s;
    assign sq_s       = (a_i[31] ^ b_i[31]) ? (32'd0 - mq_s) : mq_s;
    assign sr_s       = a_i[31] ? (32'd0 - mr_s) : mr_s;

    // Result select per operation.
    always_comb begin
        hi_o       = hi_i;
        lo_o       = lo_i;
        div_zero_o = 1'b0;
        case (op_i)
            MULT:  {hi_o, lo_o} = prod_s_s;
            MULTU: {hi_o, lo_o} = prod_u_s;
            DIV: begin
                hi_o       = sr_s;
                lo_o       = sq_s;
                div_zero_o = (b_i == 32'd0);
            end
            DIVU: begin
                hi_o       = ur_s;
                lo_o       = uq_s;
                div_zero_o = (b_i == 32'd0);
            end
`ifdef MDU_MADD_EN
            MADD:  {hi_o, lo_o} = {hi_i, lo_i} + prod_s_s;
            MADDU: {hi_o, lo_o} = {hi_i, lo_i} + prod_u_s;
`endif
            default: begin
                hi_o       = hi_i;
                lo_o       = lo_i;
                div_zero_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; multi-cycle ops commit atomically.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU accumulate into HI/LO).
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               md_en,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic               start_out,
    output logic               busy,
    output logic [31:0]        md_rd_out,
    output logic [31:0]        hi_out,
    output logic [31:0]        lo_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    md_op_e             op_s;
    logic               busy_q,  busy_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    md_op_e             opc_q,   opc_d;
    logic [31:0]        opa_q,   opa_d;
    logic [31:0]        opb_q,   opb_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;
    logic [31:0]        res_hi_s;
    logic [31:0]        res_lo_s;
    logic               div_zero_s;

    assign op_s      = md_op_e'(md_op);
    assign start_out = md_en & is_start_class(op_s);
    assign busy      = busy_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

    // HI/LO cannot change while busy, so the live registers serve as the accumulate base.
    mdu_arith u_arith (
        .op_i       (opc_q),
        .a_i        (opa_q),
        .b_i        (opb_q),
        .hi_i       (hi_q),
        .lo_i       (lo_q),
        .hi_o       (res_hi_s),
        .lo_o       (res_lo_s),
        .div_zero_o (div_zero_s)
    );

    // Read path for MFHI/MFLO towards the Memory stage.
    always_comb begin
        md_rd_out = 32'd0;
        if (md_en) begin
            case (op_s)
                MFHI:    md_rd_out = hi_q;
                MFLO:    md_rd_out = lo_q;
                default: md_rd_out = 32'd0;
            endcase
        end else begin
            md_rd_out = 32'd0;
        end
    end

    // Next-state: countdown and commit while busy, otherwise accept a start or a direct HI/LO write.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        opc_d  = opc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (!div_zero_s) begin
                    hi_d = res_hi_s;
                    lo_d = res_lo_s;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start_out) begin
            busy_d = 1'b1;
            cnt_d  = is_div_class(op_s) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            opc_d  = op_s;
            opa_d  = rs_data;
            opb_d  = rt_data;
        end else if (md_en && (op_s == MTHI)) begin
            hi_d = rs_data;
        end else if (md_en && (op_s == MTLO)) begin
            lo_d = rs_data;
        end else begin
            busy_d = busy_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            opc_q  <= MD_NONE;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            opc_q  <= opc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed scenarios plus randomized ops vs. an arithmetic model.
// Honours MDU_MADD_EN the same way as the design build.
module tb_mult_div_unit;

    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_en;
    logic [3:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start_out;
    logic        busy;
    logic [31:0] md_rd_out;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural HI/LO, cycles left, and the result waiting to commit.
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic        m_pend_ok;
    logic [63:0] m_pend;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .md_en     (md_en),
        .md_op     (md_op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .start_out (start_out),
        .busy      (busy),
        .md_rd_out (md_rd_out),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_is_start(input logic [3:0] op);
        bit r = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MDU_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return r;
    endfunction

    // Plain 64-bit integer arithmetic; returns 0 when the op must leave HI/LO untouched.
    function automatic bit ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] hi, input logic [31:0] lo,
                                      output logic [63:0] res);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        longint          q, r;
        res = {hi, lo};
        case (op)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) return 1'b0;
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (b == 32'd0) return 1'b0;
                res = {32'(ua % ub), 32'(ua / ub)};
            end
            OP_MADD:  res = {hi, lo} + sa * sb;
            OP_MADDU: res = {hi, lo} + ua * ub;
            default:  res = {hi, lo};
        endcase
        return 1'b1;
    endfunction

    task automatic model_edge(input logic en, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pend_ok) {m_hi, m_lo} = m_pend;
        end else if (en && ref_is_start(op)) begin
            m_pend_ok = ref_result(op, a, b, m_hi, m_lo, m_pend);
            m_left    = (op == OP_DIV || op == OP_DIVU) ? N_DIV : N_MULT;
        end else if (en && op == OP_MTHI) begin
            m_hi = a;
        end else if (en && op == OP_MTLO) begin
            m_lo = a;
        end
    endtask

    task automatic model_clear();
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_pend_ok = 1'b0; m_pend = 64'd0;
    endtask

    // One clock: drive at negedge, check comb outputs, advance model at posedge, check registers.
    task automatic step(input logic en, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_rd;
        md_en = en; md_op = op; rs_data = a; rt_data = b;
        #1;
        exp_rd = (en && op == OP_MFHI) ? m_hi : (en && op == OP_MFLO) ? m_lo : 32'd0;
        check_eq("start_out", {31'd0, start_out}, {31'd0, en && ref_is_start(op)});
        check_eq("md_rd_out", md_rd_out, exp_rd);
        @(posedge clk);
        model_edge(en, op, a, b);
        #1;
        check_eq("busy", {31'd0, busy}, {31'd0, m_left > 0});
        check_eq("hi", hi_out, m_hi);
        check_eq("lo", lo_out, m_lo);
        @(negedge clk);
    endtask

    task automatic idle_until_free(output int n);
        n = 0;
        for (int i = 0; i < 20 && busy; i++) begin
            step(1'b0, OP_NONE, 32'd0, 32'd0);
            n++;
        end
    endtask

    task automatic pulse_reset();
        md_en = 1'b0; md_op = OP_NONE;
        #2 reset = 1'b1;
        model_clear();
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi_out, 32'd0);
        check_eq("rst_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [31:0] h0, l0;
        reset = 1'b1; md_en = 1'b0; md_op = OP_NONE; rs_data = 32'd0; rt_data = 32'd0;
        model_clear();
        repeat (2) @(negedge clk);
        check_eq("init_busy", {31'd0, busy}, 32'd0);
        check_eq("init_hi", hi_out, 32'd0);
        check_eq("init_lo", lo_out, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3
        step(1'b1, OP_MULT, 32'hFFFF_FFFE, 32'd3);
        idle_until_free(n);
        check_eq("t1_cycles", n, 32'd5);
        check_eq("t1_hi", hi_out, 32'hFFFF_FFFF);
        check_eq("t1_lo", lo_out, 32'hFFFF_FFFA);

        // DIVU 7/2 and DIV -7/2
        step(1'b1, OP_DIVU, 32'd7, 32'd2);
        idle_until_free(n);
        check_eq("t2_cycles", n, 32'd10);
        check_eq("t2_lo", lo_out, 32'd3);
        check_eq("t2_hi", hi_out, 32'd1);
        step(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        idle_until_free(n);
        check_eq("t2s_lo", lo_out, 32'hFFFF_FFFD);
        check_eq("t2s_hi", hi_out, 32'hFFFF_FFFF);

        // MTHI then MFHI, then divide by zero
        step(1'b1, OP_MTHI, 32'h0000_1234, 32'd0);
        md_en = 1'b1; md_op = OP_MFHI;
        #1 check_eq("t3_mfhi", md_rd_out, 32'h0000_1234);
        step(1'b1, OP_MFHI, 32'd0, 32'd0);
        h0 = hi_out; l0 = lo_out;
        step(1'b1, OP_DIV, 32'd55, 32'd0);
        idle_until_free(n);
        check_eq("t3_dz_cycles", n, 32'd10);
        check_eq("t3_dz_hi", hi_out, h0);
        check_eq("t3_dz_lo", lo_out, l0);

        // Overflow divide
        step(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_until_free(n);
        check_eq("ovf_lo", lo_out, 32'h8000_0000);
        check_eq("ovf_hi", hi_out, 32'd0);

        // MTLO issued while a MULT is busy is dropped
        step(1'b1, OP_MULT, 32'd6, 32'd7);
        step(1'b0, OP_NONE, 32'd0, 32'd0);
        step(1'b1, OP_MTLO, 32'h0000_00AA, 32'd0);
        idle_until_free(n);
        check_eq("t4_lo", lo_out, 32'd42);
        check_eq("t4_hi", hi_out, 32'd0);

        // Async reset in the middle of a DIV
        step(1'b1, OP_DIV, 32'd100, 32'd7);
        step(1'b0, OP_NONE, 32'd0, 32'd0);
        step(1'b0, OP_NONE, 32'd0, 32'd0);
        pulse_reset();
        repeat (12) step(1'b0, OP_NONE, 32'd0, 32'd0);
        check_eq("t5_hi", hi_out, 32'd0);
        check_eq("t5_lo", lo_out, 32'd0);

        // MADD onto HI=0 LO=5
        step(1'b1, OP_MTLO, 32'd5, 32'd0);
        step(1'b1, OP_MADD, 32'd2, 32'd3);
        repeat (6) step(1'b0, OP_NONE, 32'd0, 32'd0);
`ifdef MDU_MADD_EN
        check_eq("t6_lo", lo_out, 32'd11);
`else
        check_eq("t6_lo", lo_out, 32'd5);
`endif
        check_eq("t6_hi", hi_out, 32'd0);

        // Randomized traffic, including ops issued while busy
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 12)), pick_operand(), pick_operand());
        end
        repeat (12) step(1'b0, OP_NONE, 32'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
